// File: rtl/sram_defs.sv
// Shared SRAM-side definitions: default bus widths, read timeout and reader FSM encodings.
// The controller side imports this same package.
package sram_defs;

    localparam int ADDR_W_DEF  = 20;
    localparam int DATA_W_DEF  = 32;
    localparam int TIMEOUT_DEF = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_GAP   = 2'd3
    } rd_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count and a synchronous flush.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] level,
    output logic                   empty,
    output logic                   full
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level == '0);
    assign full    = (level == (PW + 1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + (PW + 1)'(1);
                2'b01:   level <= level - (PW + 1)'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/sram_stream_reader.sv
// Streams a contiguous SRAM word range through the request/done handshake into a FIFO
// that a consumer drains over valid/ready. Read-only; one request outstanding at a time.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// ST_IDLE  | no stream active; FIFO contents remain poppable
// ST_ISSUE | waiting for FIFO space, then present the next read
// ST_WAIT  | read outstanding; wait for a rising mem_done or the timeout
// ST_GAP   | one cycle with mem_read low, then next index, wrap or finish
module sram_stream_reader
    import sram_defs::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        stop,
    input  logic [ADDR_W-1:0]           base_addr,
    input  logic [ADDR_W-1:0]           length,
    input  logic                        loop,
    output logic                        busy,
    output logic                        error,
    output logic                        mem_read,
    output logic                        mem_write,
    output logic [ADDR_W-1:0]           mem_addr,
    input  logic [DATA_W-1:0]           mem_rdata,
    input  logic                        mem_done,
    output logic                        rd_valid,
    output logic [DATA_W-1:0]           rd_data,
    input  logic                        rd_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    rd_state_t         state, state_d;
    logic              done_q;
    logic              done_rise;
    logic [ADDR_W-1:0] base_q, len_q, idx_q, idx_next;
    logic              loop_q;
    logic              stop_pend;
    logic              stop_any;
    logic [TMR_W-1:0]  tmr;
    logic              do_start, do_issue, do_push, do_timeout;
    logic              fifo_empty, fifo_full;
    logic [DATA_W-1:0] fifo_dout;

    // The controller parks mem_done high between transactions, so only an edge completes a read.
    assign done_rise = mem_done && !done_q;
    assign stop_any  = stop || stop_pend;
    assign busy      = (state != ST_IDLE);
    assign mem_write = 1'b0;
    assign rd_valid  = !fifo_empty;
    assign rd_data   = fifo_empty ? '0 : fifo_dout;

    always_comb begin
        state_d    = state;
        idx_next   = idx_q;
        do_start   = 1'b0;
        do_issue   = 1'b0;
        do_push    = 1'b0;
        do_timeout = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && (length != '0)) begin
                    do_start = 1'b1;
                    idx_next = '0;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (stop_any) begin
                    state_d = ST_IDLE;
                end else if (!fifo_full) begin
                    do_issue = 1'b1;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (done_rise) begin
                    do_push = 1'b1;
                    state_d = ST_GAP;
                end else if (tmr == '0) begin
                    do_timeout = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (stop_any) begin
                    state_d = ST_IDLE;
                end else if (idx_q == len_q - ADDR_W'(1)) begin
                    if (loop_q) begin
                        idx_next = '0;
                        state_d  = ST_ISSUE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    idx_next = idx_q + ADDR_W'(1);
                    state_d  = ST_ISSUE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            done_q    <= 1'b0;
            base_q    <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            loop_q    <= 1'b0;
            stop_pend <= 1'b0;
            tmr       <= '0;
            mem_read  <= 1'b0;
            mem_addr  <= '0;
            error     <= 1'b0;
        end else begin
            state  <= state_d;
            done_q <= mem_done;
            idx_q  <= idx_next;
            if (do_start) begin
                base_q <= base_addr;
                len_q  <= length;
                loop_q <= loop;
                error  <= 1'b0;
            end
            if (state_d == ST_IDLE) begin
                stop_pend <= 1'b0;
            end else if (stop && (state != ST_IDLE)) begin
                stop_pend <= 1'b1;
            end
            // Timeout is a down-counter: loaded on issue, expires at zero.
            if (do_issue) begin
                mem_read <= 1'b1;
                mem_addr <= base_q + idx_q;
                tmr      <= TMR_W'(TIMEOUT - 1);
            end else if (state == ST_WAIT) begin
                if (do_push || do_timeout) begin
                    mem_read <= 1'b0;
                end else begin
                    tmr <= tmr - TMR_W'(1);
                end
            end
            if (do_timeout) begin
                error <= 1'b1;
            end
        end
    end

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (do_push),
        .pop   (rd_ready),
        .flush (do_start),
        .din   (mem_rdata),
        .dout  (fifo_dout),
        .level (fifo_level),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

endmodule

// File: tb/tb_sram_stream_reader.sv
// Randomized bench: SRAM responder plus an address/data reference model derived from base, length and loop.
module tb_sram_stream_reader;

    localparam int DEPTH = 8;

    localparam int W_IDLE   = 0;
    localparam int W_EMPTY  = 1;
    localparam int W_FULL   = 2;
    localparam int W_ISSUE7 = 3;
    localparam int W_PEND   = 4;
    localparam int W_ERROR  = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, stop, loop;
    logic [19:0] base_addr, length;
    logic        busy, error, mem_read, mem_write;
    logic [19:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        rd_ready;
    logic [3:0]  fifo_level;

    int checks   = 0;
    int failures = 0;

    // reference model of the active stream
    logic [19:0] m_base = '0;
    int          m_len  = 1;
    int          issue_k = 0, pop_k = 0, issue_tot = 0;

    // responder controls
    int resp_mode = 0;       // 0 pulse done, 1 done parked high, 2 never done
    int lat_lo = 1, lat_hi = 1;
    bit rdy_rand = 1'b0;
    bit rdy_fixed = 1'b1;

    int ncyc = 0, done_ncyc = 0, fall_ncyc = 0, rise_ncyc = 0, err_ncyc = 0;
    logic prev_read = 1'b0, prev_busy = 1'b0, prev_err = 1'b0;

    always #5 clk = ~clk;

    sram_stream_reader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .base_addr  (base_addr),
        .length     (length),
        .loop       (loop),
        .busy       (busy),
        .error      (error),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_done   (mem_done),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .rd_ready   (rd_ready),
        .fifo_level (fifo_level)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [19:0] a);
        return {12'h000, a} ^ 32'hA5A5A5A5;
    endfunction

    function automatic logic [19:0] addr_of(input int k);
        logic [31:0] s;
        s = {12'h000, m_base} + 32'(k % m_len);
        return s[19:0];
    endfunction

    // SRAM controller stand-in plus consumer ready generation
    initial begin : responder
        bit req_seen;
        bit given;
        int cnt;
        int cur_lat;
        req_seen  = 1'b0;
        given     = 1'b0;
        cnt       = 0;
        cur_lat   = 1;
        mem_done  = 1'b0;
        mem_rdata = '0;
        rd_ready  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            rd_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fixed;
            if (rst) begin
                req_seen = 1'b0;
                mem_done = 1'b0;
            end else if (!req_seen) begin
                mem_done = (resp_mode == 1);
                if (mem_read) begin
                    req_seen = 1'b1;
                    given    = 1'b0;
                    cnt      = 0;
                    cur_lat  = $urandom_range(lat_lo, lat_hi);
                end
            end else if (!mem_read) begin
                req_seen = 1'b0;
                mem_done = (resp_mode == 1);
            end else begin
                cnt++;
                if (resp_mode == 1 && cnt == 2) mem_done = 1'b0;
                if (resp_mode != 2 && !given && cnt == cur_lat) begin
                    mem_done  = 1'b1;
                    mem_rdata = word_of(mem_addr);
                    given     = 1'b1;
                    done_ncyc = ncyc + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        ncyc++;
        if (!rst) begin
            check_eq("mem_write_zero", 64'(mem_write), 64'd0);
            if (fifo_level == 4'(DEPTH)) check_eq("no_read_when_full", 64'(mem_read), 64'd0);
            if (mem_read && !prev_read) begin
                check_eq("issue_addr", 64'(mem_addr), 64'(addr_of(issue_k)));
                issue_k++;
                issue_tot++;
                rise_ncyc = ncyc;
            end
            if (rd_valid && rd_ready) begin
                check_eq("pop_data", 64'(rd_data), 64'(word_of(addr_of(pop_k))));
                pop_k++;
            end
        end
        if (prev_busy && !busy) fall_ncyc = ncyc;
        if (error && !prev_err) err_ncyc = ncyc;
        prev_read = mem_read;
        prev_busy = busy;
        prev_err  = error;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic bit cond_met(input int what);
        case (what)
            W_IDLE:   return !busy;
            W_EMPTY:  return !rd_valid;
            W_FULL:   return fifo_level == 4'(DEPTH);
            W_ISSUE7: return issue_k >= 7;
            W_PEND:   return mem_read && !mem_done;
            W_ERROR:  return error;
            default:  return 1'b1;
        endcase
    endfunction

    task automatic wait_for(input string tag, input int what, input int budget);
        int n;
        n = 0;
        while (!cond_met(what)) begin
            if (n >= budget) begin
                check_eq({tag, "_wait_expired"}, 64'd0, 64'd1);
                break;
            end
            tick();
            n++;
        end
    endtask

    task automatic pulse_start(input logic [19:0] b, input logic [19:0] l, input logic lp, input bit accept);
        base_addr = b;
        length    = l;
        loop      = lp;
        start     = 1'b1;
        tick();
        start = 1'b0;
        if (accept) begin
            m_base  = b;
            m_len   = int'(l);
            issue_k = 0;
            pop_k   = 0;
        end
    endtask

    initial begin
        int n0;
        int len_r;
        rst = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0;
        base_addr = '0; length = '0;
        repeat (3) tick();
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_error", 64'(error), 64'd0);
        check_eq("rst_mem_read", 64'(mem_read), 64'd0);
        check_eq("rst_mem_addr", 64'(mem_addr), 64'd0);
        check_eq("rst_rd_valid", 64'(rd_valid), 64'd0);
        check_eq("rst_fifo_level", 64'(fifo_level), 64'd0);
        rst = 1'b0;
        tick();

        // basic stream, fixed latency 5
        lat_lo = 5; lat_hi = 5; rdy_fixed = 1'b1;
        pulse_start(20'h00100, 20'd4, 1'b0, 1'b1);
        check_eq("basic_busy", 64'(busy), 64'd1);
        wait_for("basic_idle", W_IDLE, 200);
        wait_for("basic_empty", W_EMPTY, 50);
        check_eq("basic_issues", 64'(issue_k), 64'd4);
        check_eq("basic_pops", 64'(pop_k), 64'd4);
        check_eq("basic_error", 64'(error), 64'd0);

        // backpressure: 20 words into an 8-deep FIFO
        lat_lo = 1; lat_hi = 8; rdy_fixed = 1'b0;
        tick();
        pulse_start(20'($urandom_range(0, 20'hFFFFF)), 20'd20, 1'b0, 1'b1);
        wait_for("bp_full", W_FULL, 400);
        repeat (20) tick();
        check_eq("bp_issues_stalled", 64'(issue_k), 64'd8);
        check_eq("bp_level", 64'(fifo_level), 64'd8);
        check_eq("bp_read_low", 64'(mem_read), 64'd0);
        check_eq("bp_busy", 64'(busy), 64'd1);
        rdy_rand = 1'b1;
        wait_for("bp_idle", W_IDLE, 3000);
        rdy_rand = 1'b0; rdy_fixed = 1'b1;
        wait_for("bp_empty", W_EMPTY, 100);
        check_eq("bp_pops", 64'(pop_k), 64'd20);
        check_eq("bp_issues", 64'(issue_k), 64'd20);

        // loop with address wrap, then stop during a read
        lat_lo = 2; lat_hi = 6;
        pulse_start(20'hFFFFE, 20'd3, 1'b1, 1'b1);
        wait_for("loop_issues", W_ISSUE7, 300);
        wait_for("loop_pending", W_PEND, 50);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_for("stop_idle", W_IDLE, 100);
        tick();
        check_eq("stop_latency_le2", 64'((fall_ncyc - done_ncyc) <= 2), 64'd1);
        wait_for("stop_empty", W_EMPTY, 50);
        check_eq("stop_word_pushed", 64'(pop_k), 64'(issue_k));

        // mem_done parked high between reads
        resp_mode = 1; lat_lo = 3; lat_hi = 10;
        repeat (3) tick();
        len_r = $urandom_range(3, 10);
        pulse_start(20'($urandom_range(0, 20'hFFFFF)), 20'(len_r), 1'b0, 1'b1);
        wait_for("held_idle", W_IDLE, 400);
        wait_for("held_empty", W_EMPTY, 50);
        check_eq("held_issues", 64'(issue_k), 64'(len_r));
        check_eq("held_pops", 64'(pop_k), 64'(len_r));
        resp_mode = 0;
        repeat (2) tick();

        // timeout, then a fresh start clears the error
        resp_mode = 2;
        pulse_start(20'($urandom_range(0, 20'hFFFFF)), 20'd5, 1'b0, 1'b1);
        wait_for("to_error", W_ERROR, 150);
        tick();
        check_eq("to_cycles", 64'(err_ncyc - rise_ncyc), 64'd64);
        check_eq("to_read_low", 64'(mem_read), 64'd0);
        check_eq("to_busy", 64'(busy), 64'd0);
        check_eq("to_issues", 64'(issue_k), 64'd1);
        check_eq("to_no_push", 64'(rd_valid), 64'd0);
        resp_mode = 0; lat_lo = 1; lat_hi = 4;
        tick();
        pulse_start(20'($urandom_range(0, 20'hFFFFF)), 20'd4, 1'b0, 1'b1);
        check_eq("to_error_cleared", 64'(error), 64'd0);
        wait_for("to2_idle", W_IDLE, 200);
        wait_for("to2_empty", W_EMPTY, 50);
        check_eq("to2_pops", 64'(pop_k), 64'd4);
        check_eq("to2_error", 64'(error), 64'd0);

        // length 0 and stop while idle do nothing
        n0 = issue_tot;
        pulse_start(20'h00055, 20'd0, 1'b0, 1'b0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        repeat (10) tick();
        check_eq("len0_busy", 64'(busy), 64'd0);
        check_eq("len0_no_issue", 64'(issue_tot), 64'(n0));

        // start while busy is ignored
        pulse_start(20'h02000, 20'd6, 1'b0, 1'b1);
        repeat (4) tick();
        pulse_start(20'h09000, 20'd2, 1'b1, 1'b0);
        wait_for("ign_idle", W_IDLE, 300);
        wait_for("ign_empty", W_EMPTY, 50);
        check_eq("ign_issues", 64'(issue_k), 64'd6);
        check_eq("ign_pops", 64'(pop_k), 64'd6);

        // reset while a read is outstanding
        lat_lo = 4; lat_hi = 8;
        pulse_start(20'($urandom_range(0, 20'hFFFFF)), 20'd10, 1'b0, 1'b1);
        wait_for("rst_pending", W_PEND, 50);
        rst = 1'b1;
        tick();
        check_eq("midrst_mem_read", 64'(mem_read), 64'd0);
        check_eq("midrst_busy", 64'(busy), 64'd0);
        check_eq("midrst_error", 64'(error), 64'd0);
        check_eq("midrst_mem_addr", 64'(mem_addr), 64'd0);
        check_eq("midrst_level", 64'(fifo_level), 64'd0);
        check_eq("midrst_rd_valid", 64'(rd_valid), 64'd0);
        check_eq("midrst_rd_data", 64'(rd_data), 64'd0);
        rst = 1'b0;
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_stream_reader.md
Name: sram_stream_reader

Overview:
- Client-side master for the SRAM controller's request/done handshake.
- Streams a contiguous range of 32-bit words out of SRAM, one read at a time.
- Buffers the words in a small FIFO and hands them to a consumer, such as an audio sample player, over a valid/ready port.
- Sits between the SRAM controller and the playback logic; it never writes SRAM.

Parameters:
ADDR_W, 20, SRAM word address width
DATA_W, 32, SRAM data width
FIFO_DEPTH, 8, buffer depth in words; must be a power of 2, at least 2
TIMEOUT, 64, max cycles to wait for mem_done per read before flagging an error

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
start  in  1  one-cycle pulse; latch base_addr/length/loop and begin streaming
stop  in  1  one-cycle pulse; finish any in-flight read, then go idle
base_addr  in  ADDR_W  first word address
length  in  ADDR_W  number of words to stream (0 = no-op)
loop  in  1  when 1, wrap to base_addr after the last word, indefinitely
busy  out  1  high from an accepted start until return to IDLE
error  out  1  sticky timeout flag; cleared by rst or the next accepted start
mem_read  out  1  read request to the controller; held until completion
mem_write  out  1  constant 0
mem_addr  out  ADDR_W  address presented to the controller
mem_rdata  in  DATA_W  controller read data; valid when mem_done rises
mem_done  in  1  controller completion level
rd_valid  out  1  FIFO not empty
rd_data  out  DATA_W  FIFO head (show-ahead)
rd_ready  in  1  consumer pop; pop occurs when rd_valid && rd_ready
fifo_level  out  log2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; FIFO empty; done_q (registered copy of mem_done) = 0.
- Completion event: done_rise = mem_done && !done_q. A level-high mem_done is never treated as completion, because the controller holds done high between transactions.
- FSM states: IDLE, ISSUE, WAIT, GAP.
- IDLE:
  - start with length != 0: latch inputs, clear idx, flush FIFO, clear error, busy=1, go to ISSUE.
  - start with length == 0: ignored.
  - start while busy is always ignored.
- ISSUE:
  - If fifo_level < FIFO_DEPTH: mem_addr = base + idx (mod 2^ADDR_W), mem_read=1, clear timer, go to WAIT.
  - Otherwise stall in ISSUE with mem_read=0.
- WAIT:
  - mem_read stays 1 and mem_addr stays stable; timer increments each cycle.
  - On done_rise: push mem_rdata into the FIFO, mem_read=0 in the same cycle's registered output, go to GAP.
  - If the timer reaches TIMEOUT-1 without done_rise: error=1, mem_read=0, go to IDLE (busy=0). Nothing is pushed.
- GAP: one idle cycle with mem_read=0, so the controller returns to its init state. Then:
  - stop seen (pending) → IDLE.
  - idx == length-1 and !loop → IDLE.
  - idx == length-1 and loop → idx=0, go to ISSUE.
  - otherwise idx+1, go to ISSUE.
- stop handling:
  - stop is registered as pending and honored only in ISSUE or GAP; an in-flight read always completes and its word is pushed.
  - stop in IDLE has no effect.
- Latency: with mem_done rising N cycles after mem_read rises, the per-word period is N+2 cycles; the first rd_valid appears 1 cycle after the first done_rise.
- FIFO:
  - Only one read is ever outstanding, and ISSUE checks for space, so a push never meets a full FIFO.
  - Push and pop in the same cycle: level unchanged; the head advances correctly.
  - Pop while empty: ignored.
  - FIFO contents persist after return to IDLE until drained or the next start.
- Address wrap: base + idx wraps modulo 2^20 (e.g. base=0xFFFFE, idx 2 → 0x00000).
- rst mid-operation: immediate return to reset values, mem_read drops at the next edge, FIFO is emptied.

Decomposition:
- Shared header / package sram_defs: ADDR_W and DATA_W defaults, FSM state encodings, TIMEOUT default. The controller side uses the same header.
- One sub-module, sync_fifo (parameters DEPTH and WIDTH; ports push, pop, flush, din, dout, level, empty, full), with synchronous active-high reset.

Test Plan:
- Basic stream: base=0x00100, length=4, loop=0; responder returns addr^0xA5A5A5A5 after 5 cycles → FIFO receives words for addresses 0x100..0x103 in order; busy drops after the 4th GAP; mem_write is never 1.
- Backpressure: FIFO_DEPTH=8, length=20, rd_ready=0 → exactly 8 reads are issued and mem_read stays 0 while fifo_level=8. Then rd_ready=1 → all 20 words arrive in order with none lost or duplicated.
- Loop and address wrap: base=0xFFFFE, length=3, loop=1 → address sequence 0xFFFFE, 0xFFFFF, 0x00000, 0xFFFFE, ...; stop mid-read → that word is pushed and busy drops within 2 cycles after its done_rise.
- Held-done robustness: responder keeps mem_done high between transactions, dropping it 2 cycles after mem_read rises → exactly one push per read; no double push while done stays high.
- Timeout: responder never asserts mem_done, TIMEOUT=64 → error=1 and mem_read=0 64 cycles after mem_read rose; busy=0. A new start clears error and streams normally.
- Edge cases:
  - length=0 start → busy stays 0 and no request is issued.
  - start while busy → ignored, and addresses continue from the original base.
  - rst asserted in WAIT → all outputs 0 at the next edge.
